// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART word transmitter.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_ODD  = 2'd1,
      PAR_EVEN = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   // Clock cycles per bit time; the fractional part is dropped.
   function automatic int baud_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time counter: runs 0..DIV-1 while enabled and flags the last cycle of
// each bit. A clear restarts the bit so every state begins on a full bit time.
module uart_baud_tick #(
   parameter int DIV = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_clr,
   output logic o_bit_end
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   // Count cycles within the current bit, wrapping at the bit boundary.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_cnt <= '0;
      else if (i_clr)
         r_cnt <= '0;
      else if (i_en)
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
   end

   assign o_bit_end = i_en && (r_cnt == LAST);

endmodule

// File: rtl/uart_word_transmit.sv
// Multi-byte UART transmitter: accepts a word on valid/ready and sends its
// bytes as back-to-back frames (start, 8 data LSB first, optional parity,
// 1 or 2 stop bits). All outputs come straight from flops.
module uart_word_transmit #(
   parameter int CLK_FREQ_HZ    = 100_000_000,
   parameter int BAUD_RATE      = 9600,
   parameter int WORD_BYTES     = 4,
   parameter int PARITY         = 0,
   parameter int STOP_BITS      = 1,
   parameter int MSB_BYTE_FIRST = 0
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic [8*WORD_BYTES-1:0] word_in,
   input  logic                    valid_in,
   output logic                    ready_out,
   output logic                    busy_out,
   output logic                    tx_wire_out,
   output logic                    byte_done_out,
   output logic                    word_done_out
);

   import uart_pkg::*;

   localparam int DIV   = baud_div(CLK_FREQ_HZ, BAUD_RATE);
   localparam int WW    = 8 * WORD_BYTES;
   localparam int IDX_W = $clog2(WORD_BYTES + 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORD_BYTES - 1);
   localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

   if (DIV < 2) begin : g_chk_div
      $error("uart_word_transmit: CLK_FREQ_HZ/BAUD_RATE must be >= 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
      $error("uart_word_transmit: STOP_BITS must be 1 or 2");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_chk_par
      $error("uart_word_transmit: PARITY must be 0, 1 or 2");
   end

   tx_state_e        r_state, w_state_nxt;
   logic [2:0]       r_bit,   w_bit_nxt;
   logic [7:0]       r_byte,  w_byte_nxt;
   logic [WW-1:0]    r_word,  w_word_nxt;
   logic [IDX_W-1:0] r_idx,   w_idx_nxt;
   logic             w_tx_nxt, w_byte_done, w_word_done;
   logic             w_bit_end, w_clr, w_en;
   logic             r_tx, r_ready, r_busy, r_byte_done, r_word_done;

   // Byte that goes on the line next, taken from the configured end of the word.
   function automatic logic [7:0] head_byte(input logic [WW-1:0] w);
      if (MSB_BYTE_FIRST != 0) return w[WW-1 -: 8];
      else                     return w[7:0];
   endfunction

   // Word with the head byte removed.
   function automatic logic [WW-1:0] pop_byte(input logic [WW-1:0] w);
      if (MSB_BYTE_FIRST != 0) return w << 8;
      else                     return w >> 8;
   endfunction

   function automatic logic par_bit(input logic [7:0] b);
      return (PARITY == int'(PAR_ODD)) ? ~^b : ^b;
   endfunction

   assign w_en  = (r_state != IDLE);
   assign w_clr = (w_state_nxt != r_state);

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .i_clk     (clk_in),
      .i_rst     (rst_in),
      .i_en      (w_en),
      .i_clr     (w_clr),
      .o_bit_end (w_bit_end)
   );

   // Next-state, datapath and next line level; tx is derived from the state
   // being entered so the registered line changes exactly at bit boundaries.
   always_comb begin
      w_state_nxt = r_state;
      w_bit_nxt   = r_bit;
      w_byte_nxt  = r_byte;
      w_word_nxt  = r_word;
      w_idx_nxt   = r_idx;
      w_byte_done = 1'b0;
      w_word_done = 1'b0;
      case (r_state)
         IDLE: begin
            if (valid_in && r_ready) begin
               w_state_nxt = START;
               w_byte_nxt  = head_byte(word_in);
               w_word_nxt  = pop_byte(word_in);
               w_idx_nxt   = '0;
               w_bit_nxt   = '0;
            end
         end
         START: begin
            if (w_bit_end) w_state_nxt = DATA;
         end
         DATA: begin
            if (w_bit_end) begin
               if (r_bit == 3'd7) begin
                  w_bit_nxt   = '0;
                  w_state_nxt = (PARITY == int'(PAR_NONE)) ? STOP : uart_pkg::PARITY;
               end else begin
                  w_bit_nxt = r_bit + 3'd1;
               end
            end
         end
         uart_pkg::PARITY: begin
            if (w_bit_end) w_state_nxt = STOP;
         end
         STOP: begin
            if (w_bit_end) begin
               if (r_bit == LAST_STOP) begin
                  w_bit_nxt   = '0;
                  w_byte_done = 1'b1;
                  if (r_idx == LAST_IDX) begin
                     w_word_done = 1'b1;
                     w_state_nxt = IDLE;
                  end else begin
                     w_state_nxt = START;
                     w_idx_nxt   = r_idx + 1'b1;
                     w_byte_nxt  = head_byte(r_word);
                     w_word_nxt  = pop_byte(r_word);
                  end
               end else begin
                  w_bit_nxt = r_bit + 3'd1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      case (w_state_nxt)
         START:            w_tx_nxt = 1'b0;
         DATA:             w_tx_nxt = w_byte_nxt[w_bit_nxt];
         uart_pkg::PARITY: w_tx_nxt = par_bit(w_byte_nxt);
         default:          w_tx_nxt = 1'b1;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Bit/byte counters and the byte and word shift registers.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_bit  <= '0;
         r_byte <= '0;
         r_word <= '0;
         r_idx  <= '0;
      end else begin
         r_bit  <= w_bit_nxt;
         r_byte <= w_byte_nxt;
         r_word <= w_word_nxt;
         r_idx  <= w_idx_nxt;
      end
   end

   // Registered outputs; reset forces the line high and the handshake idle.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_tx        <= 1'b1;
         r_ready     <= 1'b1;
         r_busy      <= 1'b0;
         r_byte_done <= 1'b0;
         r_word_done <= 1'b0;
      end else begin
         r_tx        <= w_tx_nxt;
         r_ready     <= (w_state_nxt == IDLE);
         r_busy      <= (w_state_nxt != IDLE);
         r_byte_done <= w_byte_done;
         r_word_done <= w_word_done;
      end
   end

   assign tx_wire_out   = r_tx;
   assign ready_out     = r_ready;
   assign busy_out      = r_busy;
   assign byte_done_out = r_byte_done;
   assign word_done_out = r_word_done;

endmodule

// File: tb/tb_uart_word_transmit.sv
// Directed bench for uart_word_transmit: five instances with different
// parameter sets share one clock and reset; a line receiver decodes frames.
module tb_uart_word_transmit;

   localparam int DA = 10;   // ch0: 100/10
   localparam int DS = 4;    // ch1..3: 16/4
   localparam int DE = 5;    // ch4: 50/10

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [31:0] word_a = '0;
   logic [7:0]  word_b = '0, word_c = '0, word_d = '0;
   logic [15:0] word_e = '0;
   logic [4:0]  valid  = '0;
   wire  [4:0]  ready, busy, tx, bdone, wdone;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int bd_cnt[5] = '{default: 0};
   int wd_cnt[5] = '{default: 0};

   // ch0: 4 bytes, no parity, 1 stop, LSB byte first
   uart_word_transmit #(.CLK_FREQ_HZ(100), .BAUD_RATE(10), .WORD_BYTES(4), .PARITY(0),
      .STOP_BITS(1), .MSB_BYTE_FIRST(0)) u_a (
      .clk_in(clk), .rst_in(rst), .word_in(word_a), .valid_in(valid[0]),
      .ready_out(ready[0]), .busy_out(busy[0]), .tx_wire_out(tx[0]),
      .byte_done_out(bdone[0]), .word_done_out(wdone[0]));
   // ch1: 1 byte, even parity
   uart_word_transmit #(.CLK_FREQ_HZ(16), .BAUD_RATE(4), .WORD_BYTES(1), .PARITY(2),
      .STOP_BITS(1), .MSB_BYTE_FIRST(0)) u_b (
      .clk_in(clk), .rst_in(rst), .word_in(word_b), .valid_in(valid[1]),
      .ready_out(ready[1]), .busy_out(busy[1]), .tx_wire_out(tx[1]),
      .byte_done_out(bdone[1]), .word_done_out(wdone[1]));
   // ch2: 1 byte, odd parity
   uart_word_transmit #(.CLK_FREQ_HZ(16), .BAUD_RATE(4), .WORD_BYTES(1), .PARITY(1),
      .STOP_BITS(1), .MSB_BYTE_FIRST(0)) u_c (
      .clk_in(clk), .rst_in(rst), .word_in(word_c), .valid_in(valid[2]),
      .ready_out(ready[2]), .busy_out(busy[2]), .tx_wire_out(tx[2]),
      .byte_done_out(bdone[2]), .word_done_out(wdone[2]));
   // ch3: 1 byte, no parity
   uart_word_transmit #(.CLK_FREQ_HZ(16), .BAUD_RATE(4), .WORD_BYTES(1), .PARITY(0),
      .STOP_BITS(1), .MSB_BYTE_FIRST(0)) u_d (
      .clk_in(clk), .rst_in(rst), .word_in(word_d), .valid_in(valid[3]),
      .ready_out(ready[3]), .busy_out(busy[3]), .tx_wire_out(tx[3]),
      .byte_done_out(bdone[3]), .word_done_out(wdone[3]));
   // ch4: 2 bytes, 2 stop bits, top byte first
   uart_word_transmit #(.CLK_FREQ_HZ(50), .BAUD_RATE(10), .WORD_BYTES(2), .PARITY(0),
      .STOP_BITS(2), .MSB_BYTE_FIRST(1)) u_e (
      .clk_in(clk), .rst_in(rst), .word_in(word_e), .valid_in(valid[4]),
      .ready_out(ready[4]), .busy_out(busy[4]), .tx_wire_out(tx[4]),
      .byte_done_out(bdone[4]), .word_done_out(wdone[4]));

   // Cycle counter and done-pulse tallies (pulse seen before an edge is counted at it).
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 5; i++) begin
         bd_cnt[i] <= bd_cnt[i] + (bdone[i] ? 1 : 0);
         wd_cnt[i] <= wd_cnt[i] + (wdone[i] ? 1 : 0);
      end
   end

   // Expected frame bits, index 0 = start bit; unused upper bits read as idle 1.
   function automatic logic [11:0] exp_frame(input logic [7:0] b, input int par);
      logic [11:0] f;
      f = '1;
      f[0] = 1'b0;
      f[8:1] = b;
      if (par == 1)      f[9] = ~^b;
      else if (par == 2) f[9] = ^b;
      return f;
   endfunction

   // Line receiver: waits (bounded) for a start bit, then samples nbits bit
   // times of div cycles each, flagging any change inside a bit. Called and
   // returns on a negedge; gap = idle cycles seen before the start bit.
   task automatic rx_frame(input int ch, input int div, input int nbits,
                           output logic [11:0] bits, output bit ok, output int gap);
      gap = 0;
      while (tx[ch] !== 1'b0 && gap < 2000) begin
         @(negedge clk);
         gap++;
      end
      ok = (gap < 2000);
      bits = '1;
      for (int b = 0; b < nbits; b++) begin
         for (int c = 0; c < div; c++) begin
            if (c == 0) bits[b] = tx[ch];
            else if (tx[ch] !== bits[b]) ok = 1'b0;
            @(negedge clk);
         end
      end
   endtask

   // Present a word and return on the negedge after the accepting edge.
   task automatic send(input int ch, input logic [31:0] w, output int acc);
      int t;
      @(negedge clk);
      case (ch)
         0:       word_a = w;
         1:       word_b = w[7:0];
         2:       word_c = w[7:0];
         3:       word_d = w[7:0];
         default: word_e = w[15:0];
      endcase
      valid[ch] = 1'b1;
      t = 0;
      while (ready[ch] !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (t >= 100) begin
         errors++;
         $display("FAIL send_ready ch%0d: ready never rose within %0d cycles", ch, t);
      end
      @(negedge clk);
      valid[ch] = 1'b0;
      acc = cyc;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (tx !== 5'h1f) begin errors++; $display("FAIL rst_tx got %b want 11111", tx); end
      checks++;
      if (ready !== 5'h1f) begin errors++; $display("FAIL rst_ready got %b want 11111", ready); end
      checks++;
      if (busy !== 5'h00) begin errors++; $display("FAIL rst_busy got %b want 00000", busy); end
      checks++;
      if ({bdone, wdone} !== 10'h0) begin
         errors++; $display("FAIL rst_pulses got %b/%b want 0", bdone, wdone);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({tx, ready, busy} !== 15'h7fe0) begin
         errors++; $display("FAIL idle_after_rst got %b/%b/%b", tx, ready, busy);
      end
   endtask

   task automatic test_word();
      logic [11:0] f;
      bit          ok;
      int          gap, acc;
      logic [7:0]  eb[4] = '{8'h81, 8'h0F, 8'h3C, 8'hA5};
      send(0, 32'hA53C0F81, acc);
      checks++;
      if ({ready[0], busy[0], tx[0]} !== 3'b010) begin
         errors++; $display("FAIL accept_state got %b want 010", {ready[0], busy[0], tx[0]});
      end
      for (int i = 0; i < 4; i++) begin
         rx_frame(0, DA, 10, f, ok, gap);
         checks++;
         if ({ok, gap == 0, bdone[0], wdone[0], f} !== {3'b111, i == 3, exp_frame(eb[i], 0)}) begin
            errors++;
            $display("FAIL word_byte%0d got ok=%0d gap=%0d bd=%b wd=%b f=%h want f=%h",
                     i, ok, gap, bdone[0], wdone[0], f, exp_frame(eb[i], 0));
         end
      end
      // word_done lies in the (40*DIV+1)th cycle counting the accept cycle as 1
      checks++;
      if (cyc - acc != 40 * DA) begin
         errors++; $display("FAIL word_latency got %0d want %0d", cyc - acc, 40 * DA);
      end
   endtask

   task automatic test_parity();
      logic [11:0] f;
      bit          ok;
      int          gap, acc;
      send(1, 32'h07, acc);
      rx_frame(1, DS, 11, f, ok, gap);
      checks++;
      if ({ok, wdone[1], f} !== {2'b11, 12'hE0E}) begin
         errors++; $display("FAIL par_even got ok=%0d wd=%b f=%h want f=e0e", ok, wdone[1], f);
      end
      send(2, 32'h07, acc);
      rx_frame(2, DS, 11, f, ok, gap);
      checks++;
      if ({ok, wdone[2], f} !== {2'b11, 12'hC0E}) begin
         errors++; $display("FAIL par_odd got ok=%0d wd=%b f=%h want f=c0e", ok, wdone[2], f);
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] f;
      bit          ok, low_seen;
      int          gap, wd0;
      logic [7:0]  e1[4] = '{8'h44, 8'h33, 8'h22, 8'h11};
      logic [7:0]  e2[4] = '{8'h42, 8'h00, 8'hFE, 8'hCA};
      wd0 = wd_cnt[0];
      @(negedge clk);
      word_a   = 32'h11223344;
      valid[0] = 1'b1;
      @(negedge clk);
      // second word queued while the first is in flight; valid stays high
      word_a = 32'hCAFE0042;
      for (int i = 0; i < 4; i++) begin
         rx_frame(0, DA, 10, f, ok, gap);
         checks++;
         if ({ok, gap == 0, bdone[0], f} !== {3'b111, exp_frame(e1[i], 0)}) begin
            errors++; $display("FAIL b2b_w1_byte%0d got ok=%0d gap=%0d f=%h want %h",
                               i, ok, gap, f, exp_frame(e1[i], 0));
         end
      end
      checks++;
      if ({wdone[0], ready[0], tx[0]} !== 3'b111) begin
         errors++; $display("FAIL b2b_idle_cycle got %b want 111", {wdone[0], ready[0], tx[0]});
      end
      @(negedge clk);
      valid[0] = 1'b0;
      checks++;
      if ({tx[0], busy[0]} !== 2'b01) begin
         errors++; $display("FAIL b2b_second_start got %b want 01", {tx[0], busy[0]});
      end
      for (int i = 0; i < 4; i++) begin
         rx_frame(0, DA, 10, f, ok, gap);
         checks++;
         if ({ok, gap == 0, f} !== {2'b11, exp_frame(e2[i], 0)}) begin
            errors++; $display("FAIL b2b_w2_byte%0d got ok=%0d gap=%0d f=%h want %h",
                               i, ok, gap, f, exp_frame(e2[i], 0));
         end
      end
      low_seen = 1'b0;
      repeat (3 * DA) begin
         @(negedge clk);
         if (tx[0] !== 1'b1) low_seen = 1'b1;
      end
      checks++;
      if (low_seen || wd_cnt[0] - wd0 != 2) begin
         errors++; $display("FAIL b2b_no_extra got low=%0d words=%0d want 0/2", low_seen, wd_cnt[0] - wd0);
      end
   endtask

   task automatic test_reset_mid();
      logic [11:0] f;
      bit          ok;
      int          gap, acc, bd0, wd0;
      logic [7:0]  eb[4] = '{8'h67, 8'h45, 8'h23, 8'h01};
      bd0 = bd_cnt[0];
      wd0 = wd_cnt[0];
      send(0, 32'hDEADBEEF, acc);
      // middle of data bit 1 of byte 2 (0xAD -> bit1 = 0)
      repeat (22 * DA + DA / 2) @(negedge clk);
      checks++;
      if (tx[0] !== 1'b0) begin errors++; $display("FAIL mid_bit_level got %b want 0", tx[0]); end
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({tx[0], ready[0], busy[0], bdone[0], wdone[0]} !== 5'b11000) begin
         errors++; $display("FAIL async_rst got %b want 11000",
                            {tx[0], ready[0], busy[0], bdone[0], wdone[0]});
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bd_cnt[0] - bd0 != 2 || wd_cnt[0] - wd0 != 0) begin
         errors++; $display("FAIL abort_pulses got bytes=%0d words=%0d want 2/0",
                            bd_cnt[0] - bd0, wd_cnt[0] - wd0);
      end
      send(0, 32'h01234567, acc);
      for (int i = 0; i < 4; i++) begin
         rx_frame(0, DA, 10, f, ok, gap);
         checks++;
         if ({ok, gap == 0, wdone[0], f} !== {2'b11, i == 3, exp_frame(eb[i], 0)}) begin
            errors++; $display("FAIL post_rst_byte%0d got ok=%0d gap=%0d f=%h want %h",
                               i, ok, gap, f, exp_frame(eb[i], 0));
         end
      end
   endtask

   task automatic test_stop2_msb();
      logic [11:0] f;
      bit          ok;
      int          gap, acc, bd0, wd0;
      bd0 = bd_cnt[4];
      wd0 = wd_cnt[4];
      send(4, 32'h1234, acc);
      rx_frame(4, DE, 11, f, ok, gap);
      checks++;
      if ({ok, gap == 0, bdone[4], wdone[4], f} !== {4'b1110, 12'hE24}) begin
         errors++; $display("FAIL stop2_byte0 got ok=%0d gap=%0d wd=%b f=%h want e24", ok, gap, wdone[4], f);
      end
      rx_frame(4, DE, 11, f, ok, gap);
      checks++;
      if ({ok, gap == 0, bdone[4], wdone[4], f} !== {4'b1111, 12'hE68}) begin
         errors++; $display("FAIL stop2_byte1 got ok=%0d gap=%0d wd=%b f=%h want e68", ok, gap, wdone[4], f);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bd_cnt[4] - bd0 != 2 || wd_cnt[4] - wd0 != 1) begin
         errors++; $display("FAIL stop2_pulses got bytes=%0d words=%0d want 2/1",
                            bd_cnt[4] - bd0, wd_cnt[4] - wd0);
      end
   endtask

   task automatic test_exhaustive();
      logic [11:0] f, e;
      bit          ok;
      int          gap, acc, par;
      for (int ch = 1; ch <= 3; ch++) begin
         par = (ch == 1) ? 2 : (ch == 2) ? 1 : 0;
         for (int b = 0; b < 256; b++) begin
            send(ch, 32'(b), acc);
            rx_frame(ch, DS, (ch == 3) ? 10 : 11, f, ok, gap);
            e = exp_frame(8'(b), par);
            checks++;
            if ({ok, gap == 0, wdone[ch], f} !== {3'b111, e}) begin
               errors++; $display("FAIL exh_ch%0d_byte%02h got ok=%0d gap=%0d wd=%b f=%h want %h",
                                  ch, b, ok, gap, wdone[ch], f, e);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_parity();
      test_back_to_back();
      test_reset_mid();
      test_stop2_msb();
      test_exhaustive();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
